instruction_fetch_stage: RTL and testbench
==========================================

# instruction_fetch_stage

Fetch stage of the 5-stage MIPS pipeline. Holds the PC, issues requests to instruction memory over a req/ack handshake, and owns the IF/ID pipeline register. Consumes `pc_freeze`, `IF_ID_freeze` and the EX-stage branch redirect, and produces the IF/ID fields that the hazard detection and decode logic read.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC value loaded by reset; bits [1:0] must be 0.
- `clk`  in  1  pipeline clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `pc_freeze`  in  1  from hazard unit; hold PC.
- `IF_ID_freeze`  in  1  from hazard unit; hold IF/ID register.
- `branch_taken`  in  1  EX-stage redirect strobe.
- `branch_target`  in  32  redirect address; bits [1:0] ignored and forced to 0.
- `imem_req`  out  1  instruction memory request.
- `imem_addr`  out  32  request address; stable while `imem_req`=1 and no ack.
- `imem_ack`  in  1  data valid; may be asserted in the same cycle as `imem_req`.
- `imem_data`  in  32  instruction word, valid when `imem_ack`=1.
- `pc`  out  32  current architectural fetch PC.
- `IF_ID_Instruction`  out  32  instruction in IF/ID; 32'h0 (NOP) when invalid.
- `IF_ID_PC_plus4`  out  32  fetch address + 4 of that instruction.
- `IF_ID_valid`  out  1  IF/ID holds a real instruction.
- `fetch_stall_count`  out  32  present only with `FETCH_STALL_CNT_EN`.

## Operation
- `stall` = `pc_freeze` | `IF_ID_freeze`. The two are treated identically: no partial advance.
- `word` = `imem_ack` in FETCH/DRAIN, or buffer full in HOLD.
- `accept` = `word` & !`stall` & !`branch_taken` & state != DRAIN.
- States:
  - FETCH: `imem_req`=1, `imem_addr`=`pc`.
    - Ack & accept: IF/ID <= {`imem_data`, `pc`+4, valid=1}; `pc` <= `pc`+4; stay.
    - Ack & stall & !branch: capture `imem_data` into the hold buffer; go to HOLD.
    - Ack & branch: discard the word; `pc` <= target; stay.
    - No ack & branch: latch the old address into `req_addr`; `pc` <= target; go to DRAIN.
    - No ack & no branch: stay.
  - HOLD: `imem_req`=0.
    - Branch: drop the buffer; `pc` <= target; go to FETCH.
    - Else if !stall: IF/ID <= buffer; `pc` <= `pc`+4; go to FETCH.
  - DRAIN: `imem_req`=1, `imem_addr`=`req_addr`.
    - On ack: discard the word; go to FETCH.
    - Branch during DRAIN: `pc` <= new target; stay.
- IF/ID update priority, highest first:
  1. `branch_taken`: load bubble (instr 0, PC_plus4 0, valid 0).
  2. `stall`: hold.
  3. `accept`: load the word.
  4. Otherwise: load bubble.
- Priority among PC updates: `reset` > `branch_taken` > `stall` > advance.
- `pc`+4 wraps modulo 2^32.

## Timing
- Reset (synchronous): `pc`=`RESET_PC`, state=FETCH, IF/ID={0,0,0}, buffer empty, counter 0, and `imem_req`=0 during the reset cycle.
- First request is made in the first cycle after `reset` deasserts.
- Latency: a word acked at edge N is on the IF/ID outputs after edge N. With same-cycle ack, throughput is one instruction per cycle.
- `imem_req`, `imem_addr` and `pc` are registered/state-decoded; nothing combinational passes from `imem_ack` to `imem_req`.
- Branch asserted at edge N: IF/ID is invalid after N; a request to the target is issued in cycle N+1, or after DRAIN completes.
- Stall released at edge N from HOLD: buffered word is on IF/ID after N, and the next request is in cycle N+1.
- Reset mid-DRAIN or mid-HOLD: the outstanding transaction is abandoned and any later ack is ignored until the state is FETCH. The memory must tolerate a dropped request.

## Configuration
- `FETCH_STALL_CNT_EN` defined:
  - `fetch_stall_count` port exists.
  - It increments each cycle with `stall`=1 and `reset`=0, and saturates at 32'hFFFF_FFFF.
  - It resets to 0.
- `FETCH_STALL_CNT_EN` undefined: port and counter are absent. All other behaviour is identical.

## Test plan
- Reset release with `RESET_PC`=0 and ack tied high -> `imem_addr` sequence 0,4,8; IF_ID_PC_plus4 sequence 4,8,12 one cycle later; valid=1 continuously.
- Stall held 3 cycles with word acked at addr 8 -> HOLD state and `imem_req`=0; IF/ID holds the addr-4 word; after release, IF/ID gets the addr-8 word with PC_plus4=12, then a request to 12.
- `branch_taken` with target 32'h40 while ack is delayed 2 cycles -> DRAIN keeps `imem_addr` at the old address; late word is discarded; IF_ID_valid=0; next request is 0x40.
- `branch_taken` together with stall and ack in the same cycle -> IF/ID bubble; `pc`=target; word discarded.
- PC at 32'hFFFF_FFFC with ack -> `pc` wraps to 0; IF_ID_PC_plus4=0.
- With `FETCH_STALL_CNT_EN`: 5 stall cycles -> count=5; reset asserted mid-count -> count=0 and IF_ID_valid=0.

Source files
------------

// File: rtl/instruction_fetch_stage.sv
// MIPS IF stage: PC register, req/ack instruction-memory fetch FSM and the IF/ID pipeline register.
// Optional stall-cycle counter is built when FETCH_STALL_CNT_EN is defined.
module instruction_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pc_freeze,
  input  logic        IF_ID_freeze,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_data,
  output logic [31:0] pc,
  output logic [31:0] IF_ID_Instruction,
  output logic [31:0] IF_ID_PC_plus4,
  output logic        IF_ID_valid
`ifdef FETCH_STALL_CNT_EN
  ,
  output logic [31:0] fetch_stall_count
`endif
);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_HOLD  = 2'd1,
    S_DRAIN = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] req_addr_q, req_addr_d;
  logic [31:0] buf_q, buf_d;
  logic [31:0] ifid_instr_q, ifid_instr_d;
  logic [31:0] ifid_pc4_q, ifid_pc4_d;
  logic        ifid_valid_q, ifid_valid_d;

  logic        stall;
  logic        word;
  logic        accept;
  logic [31:0] target;
  logic [31:0] pc_plus4;
  logic        unused_target_lsbs;

  assign stall              = pc_freeze | IF_ID_freeze;
  assign target             = {branch_target[31:2], 2'b00};
  assign unused_target_lsbs = ^branch_target[1:0];
  assign pc_plus4           = pc_q + 32'd4;
  assign word               = (state_q == S_HOLD) ? 1'b1 : imem_ack;
  assign accept             = word & ~stall & ~branch_taken & (state_q != S_DRAIN);

  // The request is decoded from state only; reset gates it so nothing is issued in the reset cycle.
  assign imem_req          = ~reset & (state_q != S_HOLD);
  assign imem_addr         = (state_q == S_DRAIN) ? req_addr_q : pc_q;
  assign pc                = pc_q;
  assign IF_ID_Instruction = ifid_instr_q;
  assign IF_ID_PC_plus4    = ifid_pc4_q;
  assign IF_ID_valid       = ifid_valid_q;

  always_comb begin
    // NOTE: every next-state signal gets a default first so no path leaves it unassigned (no latches).
    state_d      = state_q;
    pc_d         = pc_q;
    req_addr_d   = req_addr_q;
    buf_d        = buf_q;
    ifid_instr_d = ifid_instr_q;
    ifid_pc4_d   = ifid_pc4_q;
    ifid_valid_d = ifid_valid_q;

    if (branch_taken) begin
      ifid_instr_d = 32'h0;
      ifid_pc4_d   = 32'h0;
      ifid_valid_d = 1'b0;
    end else if (stall) begin
      // IF/ID holds its contents.
    end else if (accept) begin
      ifid_instr_d = (state_q == S_HOLD) ? buf_q : imem_data;
      ifid_pc4_d   = pc_plus4;
      ifid_valid_d = 1'b1;
    end else begin
      ifid_instr_d = 32'h0;
      ifid_pc4_d   = 32'h0;
      ifid_valid_d = 1'b0;
    end

    unique case (state_q)
      S_FETCH: begin
        if (imem_ack) begin
          if (branch_taken) begin
            pc_d = target;
          end else if (stall) begin
            buf_d   = imem_data;
            state_d = S_HOLD;
          end else begin
            pc_d = pc_plus4;
          end
        end else if (branch_taken) begin
          // The old request is still outstanding; keep presenting its address until acked.
          req_addr_d = pc_q;
          pc_d       = target;
          state_d    = S_DRAIN;
        end
      end
      S_HOLD: begin
        if (branch_taken) begin
          pc_d    = target;
          state_d = S_FETCH;
        end else if (!stall) begin
          pc_d    = pc_plus4;
          state_d = S_FETCH;
        end
      end
      S_DRAIN: begin
        if (branch_taken) pc_d = target;
        if (imem_ack) state_d = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
  end

`ifdef FETCH_STALL_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  assign stall_cnt_d       = (stall && stall_cnt_q != 32'hFFFF_FFFF) ? stall_cnt_q + 32'd1 : stall_cnt_q;
  assign fetch_stall_count = stall_cnt_q;
`endif

  always_ff @(posedge clk) begin
    // NOTE: state updates use non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      state_q      <= S_FETCH;
      pc_q         <= {RESET_PC[31:2], 2'b00};
      req_addr_q   <= 32'h0;
      buf_q        <= 32'h0;
      ifid_instr_q <= 32'h0;
      ifid_pc4_q   <= 32'h0;
      ifid_valid_q <= 1'b0;
`ifdef FETCH_STALL_CNT_EN
      stall_cnt_q  <= 32'h0;
`endif
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      req_addr_q   <= req_addr_d;
      buf_q        <= buf_d;
      ifid_instr_q <= ifid_instr_d;
      ifid_pc4_q   <= ifid_pc4_d;
      ifid_valid_q <= ifid_valid_d;
`ifdef FETCH_STALL_CNT_EN
      stall_cnt_q  <= stall_cnt_d;
`endif
    end
  end

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Directed bench for instruction_fetch_stage: scoreboard of expected IF/ID words plus point checks.
// Define FETCH_STALL_CNT_EN to also exercise the stall counter.
module tb_instruction_fetch_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        pc_freeze;
  logic        IF_ID_freeze;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_data;
  logic [31:0] pc;
  logic [31:0] IF_ID_Instruction;
  logic [31:0] IF_ID_PC_plus4;
  logic        IF_ID_valid;
`ifdef FETCH_STALL_CNT_EN
  logic [31:0] fetch_stall_count;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc4;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  assign imem_data = mem_word(imem_addr);

  instruction_fetch_stage dut (
    .clk               (clk),
    .reset             (reset),
    .pc_freeze         (pc_freeze),
    .IF_ID_freeze      (IF_ID_freeze),
    .branch_taken      (branch_taken),
    .branch_target     (branch_target),
    .imem_req          (imem_req),
    .imem_addr         (imem_addr),
    .imem_ack          (imem_ack),
    .imem_data         (imem_data),
    .pc                (pc),
    .IF_ID_Instruction (IF_ID_Instruction),
    .IF_ID_PC_plus4    (IF_ID_PC_plus4),
    .IF_ID_valid       (IF_ID_valid)
`ifdef FETCH_STALL_CNT_EN
    ,
    .fetch_stall_count (fetch_stall_count)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] addr);
    exp_t e;
    e.instr = mem_word(addr);
    e.pc4   = addr + 32'd4;
    sb.push_back(e);
  endtask

  task automatic pop_check(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s: observed empty scoreboard expected entry", tag);
    end else begin
      e = sb.pop_front();
      check({tag, "_instr"}, IF_ID_Instruction, e.instr);
      check({tag, "_pc4"}, IF_ID_PC_plus4, e.pc4);
      check({tag, "_valid"}, {31'b0, IF_ID_valid}, 32'd1);
    end
  endtask

  task automatic check_bubble(input string tag);
    check({tag, "_valid"}, {31'b0, IF_ID_valid}, 32'd0);
    check({tag, "_instr"}, IF_ID_Instruction, 32'h0);
    check({tag, "_pc4"}, IF_ID_PC_plus4, 32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; pc_freeze = 1'b0; IF_ID_freeze = 1'b0;
    branch_taken = 1'b0; branch_target = 32'h0; imem_ack = 1'b1;
    #1;
    check("req_in_reset", {31'b0, imem_req}, 32'd0);
    tick();
    tick();
    check("rst_pc", pc, 32'h0);
    check_bubble("rst_ifid");
    check("rst_req", {31'b0, imem_req}, 32'd0);

    // Back-to-back fetch with ack tied high.
    reset = 1'b0;
    #1;
    check("first_req", {31'b0, imem_req}, 32'd1);
    check("addr0", imem_addr, 32'h0);
    push(32'h0); tick(); pop_check("f0");
    check("addr4", imem_addr, 32'h4);
    push(32'h4); tick(); pop_check("f4");
    check("addr8", imem_addr, 32'h8);

    // Three stall cycles with the addr-8 word acked on the first.
    pc_freeze = 1'b1;
    tick();
    check("hold_req", {31'b0, imem_req}, 32'd0);
    check("hold_ifid_instr", IF_ID_Instruction, mem_word(32'h4));
    check("hold_ifid_pc4", IF_ID_PC_plus4, 32'h8);
    check("hold_pc", pc, 32'h8);
    tick();
    check("hold_req2", {31'b0, imem_req}, 32'd0);
    pc_freeze = 1'b0; IF_ID_freeze = 1'b1;
    tick();
    check("hold_req3", {31'b0, imem_req}, 32'd0);
    check("hold_valid3", {31'b0, IF_ID_valid}, 32'd1);
    IF_ID_freeze = 1'b0;
    push(32'h8); tick(); pop_check("release");
    check("after_release_req", {31'b0, imem_req}, 32'd1);
    check("after_release_addr", imem_addr, 32'hC);
    push(32'hC); tick(); pop_check("f12");

    // Branch while the ack is delayed: DRAIN the old request at 16.
    imem_ack = 1'b0; branch_taken = 1'b1; branch_target = 32'h43;
    tick();
    branch_taken = 1'b0;
    check_bubble("br_drain");
    check("drain_pc", pc, 32'h40);
    check("drain_req", {31'b0, imem_req}, 32'd1);
    check("drain_addr", imem_addr, 32'h10);
    tick();
    check("drain_addr2", imem_addr, 32'h10);
    imem_ack = 1'b1;
    tick();
    check_bubble("drain_discard");
    check("target_addr", imem_addr, 32'h40);
    push(32'h40); tick(); pop_check("f40");

    // Branch, stall and ack all in one cycle.
    pc_freeze = 1'b1; branch_taken = 1'b1; branch_target = 32'h80;
    tick();
    pc_freeze = 1'b0; branch_taken = 1'b0;
    check_bubble("br_stall_ack");
    check("br_stall_pc", pc, 32'h80);
    check("br_stall_addr", imem_addr, 32'h80);

    // PC wrap from FFFF_FFFC.
    branch_taken = 1'b1; branch_target = 32'hFFFF_FFFC;
    tick();
    branch_taken = 1'b0;
    check("wrap_addr", imem_addr, 32'hFFFF_FFFC);
    push(32'hFFFF_FFFC); tick(); pop_check("wrap");
    check("wrap_pc", pc, 32'h0);
    push(32'h0); tick(); pop_check("after_wrap");

    // Branch taken while parked in HOLD.
    pc_freeze = 1'b1;
    tick();
    check("hold2_req", {31'b0, imem_req}, 32'd0);
    branch_taken = 1'b1; branch_target = 32'h100;
    tick();
    branch_taken = 1'b0; pc_freeze = 1'b0;
    check_bubble("hold_branch");
    check("hold_branch_pc", pc, 32'h100);
    check("hold_branch_addr", imem_addr, 32'h100);

    // Stall counting, then reset while in HOLD.
    reset = 1'b1;
    tick();
    reset = 1'b0;
`ifdef FETCH_STALL_CNT_EN
    check("cnt_rst", fetch_stall_count, 32'd0);
`endif
    push(32'h0); tick(); pop_check("post_rst");
    pc_freeze = 1'b1;
    for (int i = 0; i < 5; i++) tick();
`ifdef FETCH_STALL_CNT_EN
    check("cnt5", fetch_stall_count, 32'd5);
`endif
    check("hold3_valid", {31'b0, IF_ID_valid}, 32'd1);
    reset = 1'b1;
    #1;
    check("req_in_reset2", {31'b0, imem_req}, 32'd0);
    tick();
    reset = 1'b0; pc_freeze = 1'b0;
`ifdef FETCH_STALL_CNT_EN
    check("cnt_mid_rst", fetch_stall_count, 32'd0);
`endif
    check_bubble("mid_hold_rst");
    check("mid_hold_rst_pc", pc, 32'h0);
    #1;
    check("mid_hold_rst_req", {31'b0, imem_req}, 32'd1);
    push(32'h0); tick(); pop_check("restart");
    check("sb_empty", sb.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
